// File: rtl/m10k_seq_pkg.sv
// Shared types and default widths for the M10K read sequencer.
package m10k_seq_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;

   // Sequencer control states, also exported on the debug state port.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } seq_state_t;

endpackage

// File: rtl/m10k_seq_fifo2.sv
// Two-entry output FIFO for the M10K read sequencer.
// The head word is taken straight from storage, so it stays stable while it
// is not popped; a push while full is only legal with a pop in the same cycle.
module m10k_seq_fifo2
   import m10k_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_head_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   // Storage, pointers and occupancy; everything clears on reset so the head reads zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_head_data = r_mem[r_rd_ptr];
   assign o_full      = (r_count == 2'd2);
   assign o_empty     = (r_count == 2'd0);
   assign o_count     = r_count;

endmodule

// File: rtl/m10k_read_sequencer.sv
// Streams a block of M10K words to a valid/ready consumer.
// Handshake: a word moves when o_out_valid and i_out_ready are both 1 on a
// rising edge; o_out_valid never depends on i_out_ready and o_out_data holds
// while the word waits.
// Optional feature: define M10K_SEQ_LOOP_EN to let i_loop restart the pass
// from the sampled base address without returning to IDLE.
module m10k_read_sequencer
   import m10k_seq_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W-1:0] i_length,
   input  logic              i_loop,
   output logic [ADDR_W-1:0] o_m10k_rd_addr,
   output logic              o_m10k_rd_en,
   input  logic [DATA_W-1:0] i_m10k_rd_data,
   output logic [DATA_W-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_cur_addr,
   output seq_state_t        o_state
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   seq_state_t        r_state;
   seq_state_t        w_next_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_issue_cnt;
   logic [ADDR_W-1:0] r_xfer_cnt;
   logic [ADDR_W-1:0] r_cur_addr;
   logic              r_inflight;
   logic              r_done;

   logic              w_accept;
   logic              w_issue;
   logic              w_last_issue;
   logic              w_pop;
   logic              w_last_xfer;
   logic              w_loop;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [1:0]        w_fifo_count;
   logic [2:0]        w_slots_used;

`ifdef M10K_SEQ_LOOP_EN
   assign w_loop = i_loop;
`else
   // Single-shot build: the loop request has no effect.
   assign w_loop = i_loop & 1'b0;
`endif

   // The done cycle still counts as busy, so a start there is ignored too.
   assign w_accept     = i_start && (r_state == ST_IDLE) && !r_done;
   assign w_pop        = !w_fifo_empty && i_out_ready;
   // Slots that stay claimed after this cycle's transfer: FIFO words plus the read in flight.
   assign w_slots_used = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = (r_state == ST_ISSUE) && (w_slots_used < 3'd2) &&
                         !(w_fifo_full && !w_pop);
   assign w_last_issue = w_issue && (r_issue_cnt == r_len - ONE);
   assign w_last_xfer  = w_pop && (r_xfer_cnt == r_len - ONE);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; DRAIN ends when the last outstanding word leaves.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && (i_length != '0)) w_next_state = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (w_last_issue && !w_loop) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (w_pop && (w_fifo_count == 2'd1) && !r_inflight) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // State-derived outputs.
   always_comb begin
      o_m10k_rd_en = w_issue;
      o_busy       = (r_state != ST_IDLE) || r_done;
      o_state      = r_state;
   end

   // Pass parameters, issue/transfer counters, in-flight flag, done pulse and last address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_base      <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_xfer_cnt  <= '0;
         r_cur_addr  <= '0;
         r_inflight  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= w_last_xfer || (w_accept && (i_length == '0));
         if (w_accept) begin
            r_base      <= i_base_addr;
            r_len       <= i_length;
            r_issue_cnt <= '0;
            r_xfer_cnt  <= '0;
         end else begin
            if (w_issue) begin
               r_issue_cnt <= w_last_issue ? '0 : r_issue_cnt + ONE;
            end
            if (w_pop) begin
               r_xfer_cnt <= w_last_xfer ? '0 : r_xfer_cnt + ONE;
               r_cur_addr <= r_base + r_xfer_cnt;
            end
         end
      end
   end

   assign o_m10k_rd_addr = r_base + r_issue_cnt;
   assign o_done         = r_done;
   assign o_cur_addr     = r_cur_addr;

   m10k_seq_fifo2 #(
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (r_inflight),
      .i_push_data (i_m10k_rd_data),
      .i_pop       (w_pop),
      .o_head_data (o_out_data),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   assign o_out_valid = !w_fifo_empty;

endmodule

// File: tb/tb_m10k_read_sequencer.sv
// Testbench for m10k_read_sequencer: randomized passes against a pass-level
// reference model (address list per pass, M10K array contents, done after the
// last word of each pass, at most two words outstanding).
module tb_m10k_read_sequencer;
   import m10k_seq_pkg::*;

   localparam int AW = 8;
   localparam int DW = 8;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          i_start;
   logic [AW-1:0] i_base_addr;
   logic [AW-1:0] i_length;
   logic          i_loop;
   logic [AW-1:0] o_m10k_rd_addr;
   logic          o_m10k_rd_en;
   logic [DW-1:0] i_m10k_rd_data;
   logic [DW-1:0] o_out_data;
   logic          o_out_valid;
   logic          i_out_ready;
   logic          o_busy;
   logic          o_done;
   logic [AW-1:0] o_cur_addr;
   seq_state_t    o_state;

   m10k_read_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_start        (i_start),
      .i_base_addr    (i_base_addr),
      .i_length       (i_length),
      .i_loop         (i_loop),
      .o_m10k_rd_addr (o_m10k_rd_addr),
      .o_m10k_rd_en   (o_m10k_rd_en),
      .i_m10k_rd_data (i_m10k_rd_data),
      .o_out_data     (o_out_data),
      .o_out_valid    (o_out_valid),
      .i_out_ready    (i_out_ready),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_cur_addr     (o_cur_addr),
      .o_state        (o_state)
   );

   // ---------------- M10K model: data one cycle after the strobe ----------------
   logic [DW-1:0] mem [0:255];
   always @(posedge clk) begin
      if (o_m10k_rd_en) i_m10k_rd_data <= mem[o_m10k_rd_addr];
   end

   // ---------------- consumer ready pattern ----------------
   int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
   always @(posedge clk) begin
      #2;
      case (ready_mode)
         0:       i_out_ready = 1'b1;
         1:       i_out_ready = ~i_out_ready;
         default: i_out_ready = ($urandom_range(0, 9) < 7);
      endcase
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   logic [AW-1:0] exp_addr_q[$];    // read addresses in issue order
   logic [DW-1:0] exp_q[$];         // words in delivery order
   logic [AW-1:0] exp_waddr_q[$];   // address of each delivered word
   int            pass_len_q[$];    // pass lengths, delivery side
   int            issue_len_q[$];   // pass lengths, issue side
   logic [AW-1:0] issue_base_q[$];

   int            issued_tot = 0;
   int            xfer_tot   = 0;
   int            pass_issue = 0;
   int            pass_xfer  = 0;
   int            done_seen  = 0;
   int            cyc        = 0;
   int            xfer_first = -1;
   int            xfer_last  = -1;
   logic          exp_done   = 1'b0;
   logic [AW-1:0] exp_cur    = '0;
   logic          stall_valid = 1'b0;
   logic [DW-1:0] stall_data  = '0;
   bit            zero_pending = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name, input int act, input int exp);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // One pass of expectations: word k comes from address (base + k) mod 256.
   function automatic void push_pass(input logic [AW-1:0] base, input int len);
      logic [AW-1:0] a;
      for (int k = 0; k < len; k++) begin
         a = base + AW'(k);
         exp_addr_q.push_back(a);
         exp_waddr_q.push_back(a);
         exp_q.push_back(mem[a]);
      end
      if (len > 0) begin
         pass_len_q.push_back(len);
         issue_len_q.push_back(len);
         issue_base_q.push_back(base);
      end
   endfunction

   function automatic bit loop_effective();
`ifdef M10K_SEQ_LOOP_EN
      return i_loop;
`else
      return 1'b0;
`endif
   endfunction

   // Monitor: mid-cycle sampling of reads, transfers, done and cur_addr.
   always @(negedge clk) begin
      if (reset_n) begin
         int len_v;
         logic [AW-1:0] base_v;
         cyc++;
         check("done", o_done, exp_done);
         check("cur_addr", o_cur_addr, exp_cur);
         if (o_done) done_seen++;
         if (stall_valid && o_out_valid) check("stall_hold", o_out_data, stall_data);
         exp_done = 1'b0;
         if (i_start && zero_pending) begin
            exp_done     = 1'b1;
            zero_pending = 1'b0;
         end
         if (o_m10k_rd_en) begin
            issued_tot++;
            if (exp_addr_q.size() == 0) fail_now("unexpected_read", int'(o_m10k_rd_addr), -1);
            else check("rd_addr", o_m10k_rd_addr, exp_addr_q.pop_front());
            if (issue_len_q.size() > 0) begin
               pass_issue++;
               if (pass_issue == issue_len_q[0]) begin
                  pass_issue = 0;
                  len_v  = issue_len_q.pop_front();
                  base_v = issue_base_q.pop_front();
                  if (loop_effective()) push_pass(base_v, len_v);
               end
            end
         end
         if (o_out_valid && i_out_ready) begin
            xfer_tot++;
            if (xfer_first < 0) xfer_first = cyc;
            xfer_last = cyc;
            if (exp_q.size() == 0) fail_now("unexpected_word", int'(o_out_data), -1);
            else begin
               check("out_data", o_out_data, exp_q.pop_front());
               exp_cur = exp_waddr_q.pop_front();
            end
            if (pass_len_q.size() > 0) begin
               pass_xfer++;
               if (pass_xfer == pass_len_q[0]) begin
                  void'(pass_len_q.pop_front());
                  pass_xfer = 0;
                  exp_done  = 1'b1;
               end
            end
         end
         n_checks++;
         if (issued_tot - xfer_tot > 2) begin
            n_errors++;
            $display("FAIL outstanding: got %0d, expected <= 2 (t=%0t)", issued_tot - xfer_tot, $time);
         end
         stall_valid = o_out_valid && !i_out_ready;
         stall_data  = o_out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_pass(input logic [AW-1:0] base, input int len);
      @(posedge clk); #2;
      i_start     = 1'b1;
      i_base_addr = base;
      i_length    = AW'(len);
      xfer_first  = -1;
      push_pass(base, len);
      if (len == 0) zero_pending = 1'b1;
      @(posedge clk); #2;
      i_start = 1'b0;
   endtask

   // Wait for the pass to drain; lands in the done cycle. Optionally pokes start there.
   task automatic wait_idle(input bit poke_done, input int budget);
      int n = 0;
      while ((pass_len_q.size() != 0 || exp_addr_q.size() != 0) && n < budget) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= budget) fail_now("pass_timeout", n, budget);
      check("busy_in_done", o_busy, 1'b1);
      if (poke_done) begin
         i_start     = 1'b1;
         i_base_addr = AW'($urandom);
         i_length    = 8'd5;
         @(posedge clk); #2;
         i_start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2;
      check("busy_after", o_busy, 1'b0);
      check("state_idle", o_state, ST_IDLE);
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_en", o_m10k_rd_en, 1'b0);
      check("rst_rd_addr", o_m10k_rd_addr, '0);
      check("rst_valid", o_out_valid, 1'b0);
      check("rst_data", o_out_data, '0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_cur_addr", o_cur_addr, '0);
      check("rst_state", o_state, ST_IDLE);
   endtask

   task automatic clear_model();
      exp_addr_q.delete();
      exp_q.delete();
      exp_waddr_q.delete();
      pass_len_q.delete();
      issue_len_q.delete();
      issue_base_q.delete();
      issued_tot   = 0;
      xfer_tot     = 0;
      pass_issue   = 0;
      pass_xfer    = 0;
      exp_done     = 1'b0;
      exp_cur      = '0;
      stall_valid  = 1'b0;
      zero_pending = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- main stimulus ----------------
   initial begin
      int len;
      int mode;
      int n;
      logic [AW-1:0] base;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      i_start        = 1'b0;
      i_base_addr    = '0;
      i_length       = '0;
      i_loop         = 1'b0;
      i_out_ready    = 1'b1;
      i_m10k_rd_data = '0;

      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs();
      reset_n = 1'b1;
      @(negedge clk);
      check("rd_en_first_cycle", o_m10k_rd_en, 1'b0);

      // Straight pass with the consumer always ready: one word per cycle.
      ready_mode = 0;
      start_pass(8'h10, 4);
      wait_idle(1'b0, 200);
      check("cur_addr_final", o_cur_addr, 8'h13);
      check("throughput_4", xfer_last - xfer_first, 3);

      // Address wrap past 0xFF; a start in the done cycle must be ignored.
      start_pass(8'hFE, 4);
      wait_idle(1'b1, 200);
      check("cur_addr_wrap", o_cur_addr, 8'h01);

      // Alternating back-pressure, plus a start while busy that must be ignored.
      ready_mode = 1;
      start_pass(8'h80, 8);
      @(posedge clk); #2;
      i_start     = 1'b1;
      i_base_addr = 8'h33;
      i_length    = 8'd6;
      @(posedge clk); #2;
      i_start = 1'b0;
      wait_idle(1'b0, 300);
      check("cur_addr_toggle", o_cur_addr, 8'h87);

      // Zero-length pass: busy and done together for exactly one cycle.
      ready_mode = 0;
      start_pass(8'h55, 0);
      check("zero_busy", o_busy, 1'b1);
      check("zero_done", o_done, 1'b1);
      @(posedge clk); #2;
      check("zero_busy_after", o_busy, 1'b0);
      check("zero_done_after", o_done, 1'b0);

      // Loop request.
      i_loop = 1'b1;
`ifdef M10K_SEQ_LOOP_EN
      n = done_seen;
      start_pass(8'h20, 3);
      while (done_seen < n + 2 && cyc < 100000) begin
         @(posedge clk); #2;
      end
      check("loop_busy_held", o_busy, 1'b1);
      i_loop = 1'b0;
      wait_idle(1'b0, 300);
`else
      n = done_seen;
      start_pass(8'h20, 3);
      wait_idle(1'b0, 200);
      check("loop_ignored_dones", done_seen - n, 1);
      i_loop = 1'b0;
`endif

      // Reset in the middle of a pass.
      start_pass(8'h90, 8);
      n = 0;
      while (xfer_tot < 3 && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 200) fail_now("reset_wait_timeout", n, 200);
      #1;
      reset_n = 1'b0;
      #1;
      check_reset_outputs();
      clear_model();
      @(posedge clk); #2;
      reset_n = 1'b1;
      @(negedge clk);
      check("rd_en_after_reset", o_m10k_rd_en, 1'b0);
      start_pass(8'h40, 2);
      wait_idle(1'b0, 200);
      check("cur_addr_after_reset", o_cur_addr, 8'h41);

      // Randomized passes.
      for (int t = 0; t < 10; t++) begin
         mode       = $urandom_range(0, 2);
         ready_mode = mode;
         base       = AW'($urandom);
         len        = $urandom_range(1, 12);
         start_pass(base, len);
         wait_idle(1'(t % 2), 400);
         check("rand_cur_addr", o_cur_addr, base + AW'(len - 1));
         if (mode == 0) check("rand_throughput", xfer_last - xfer_first, len - 1);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
